// File: rtl/vec_dot_arb_pkg.sv
// Shared types and defaults for the round-robin front end of the single vec_dot unit.
package vec_dot_arb_pkg;
  localparam int DEF_SIZE         = 64;
  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_MAX_INFLIGHT = 32;
  localparam int DOT_LATENCY      = 30;
  localparam int TAG_W            = $clog2(DEF_NUM_REQ);

  typedef enum logic {ARB, HOLD} arb_state_t;

  typedef logic [2:0][DEF_SIZE-1:0] vec3_t;
endpackage

// File: rtl/tag_fifo.sv
// In-order owner-tag FIFO: push/pop in the same cycle, head readable combinationally (0-cycle read).
// Pushes are dropped when full and pops when empty; callers gate on full/empty/count.
module tag_fifo
  import vec_dot_arb_pkg::*;
#(
  parameter int WIDTH = TAG_W,
  parameter int DEPTH = DEF_MAX_INFLIGHT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/vec_dot_arbiter.sv
// Round-robin share of one dot unit; 0 added cycles on issue and return (end-to-end = dot latency).
// Issue stalls on dot tready or MAX_INFLIGHT outstanding; result back-pressure flows into the dot pipe.
module vec_dot_arbiter #(
  parameter int SIZE         = vec_dot_arb_pkg::DEF_SIZE,
  parameter int NUM_REQ      = vec_dot_arb_pkg::DEF_NUM_REQ,
  parameter int MAX_INFLIGHT = vec_dot_arb_pkg::DEF_MAX_INFLIGHT
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [NUM_REQ-1:0][2:0][SIZE-1:0] req_a_tdata,
  input  logic [NUM_REQ-1:0][2:0][SIZE-1:0] req_b_tdata,
  input  logic [NUM_REQ-1:0]                req_tvalid,
  output logic [NUM_REQ-1:0]                req_tready,
  output logic [SIZE-1:0]                   res_tdata,
  output logic [NUM_REQ-1:0]                res_tvalid,
  input  logic [NUM_REQ-1:0]                res_tready,
  output logic [2:0][SIZE-1:0]              dot_a_tdata,
  output logic [2:0][SIZE-1:0]              dot_b_tdata,
  output logic                              dot_tvalid,
  input  logic                              dot_a_tready,
  input  logic                              dot_b_tready,
  input  logic [SIZE-1:0]                   dot_res_tdata,
  input  logic                              dot_res_tvalid,
  output logic                              dot_res_tready,
  output logic                              err_orphan
);
  import vec_dot_arb_pkg::*;

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;

  arb_state_t    state_q;
  arb_state_t    state_d;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] rr_pick;
  logic [GW-1:0] grant;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] owner;
  logic [CW-1:0] inflight_cnt;
  logic          issue_ok;
  logic          dot_rdy;
  logic          fire;
  logic          tag_push;
  logic          res_fire;
  logic          fifo_empty;
  logic          fifo_full;

  // First valid requester at or after rr_ptr; the descending scan lets the nearest one win.
  always_comb begin
    int            idx;
    logic [GW-1:0] cand;
    idx     = 0;
    cand    = '0;
    rr_pick = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx  = (int'(rr_ptr) + k) % NUM_REQ;
      cand = GW'(idx);
      if (req_tvalid[cand]) rr_pick = cand;
    end
  end

  assign grant       = (state_q == HOLD) ? grant_q : rr_pick;
  assign issue_ok    = !areset && (inflight_cnt < CW'(MAX_INFLIGHT));
  assign dot_rdy     = dot_a_tready && dot_b_tready;
  assign dot_tvalid  = issue_ok && req_tvalid[grant] && (|req_tvalid);
  assign fire        = dot_tvalid && dot_rdy;
  assign tag_push    = fire && !fifo_full;
  assign dot_a_tdata = req_a_tdata[grant];
  assign dot_b_tdata = req_b_tdata[grant];

  always_comb begin
    req_tready        = '0;
    req_tready[grant] = issue_ok && dot_rdy;
  end

  // A stalled offer locks the grant so data cannot change under a pending handshake.
  always_comb begin
    state_d = state_q;
    if (fire)            state_d = ARB;
    else if (dot_tvalid) state_d = HOLD;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ARB;
      grant_q <= '0;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant;
      if (fire) rr_ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  tag_fifo #(
    .WIDTH (GW),
    .DEPTH (MAX_INFLIGHT)
  ) u_tags (
    .clk       (aclk),
    .rst       (areset),
    .push      (tag_push),
    .push_data (grant),
    .pop       (res_fire),
    .head      (owner),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (inflight_cnt)
  );

  // With no tag outstanding a result has no owner, so it is swallowed and flagged.
  assign res_tdata      = dot_res_tdata;
  assign dot_res_tready = fifo_empty || res_tready[owner];
  assign res_fire       = dot_res_tvalid && !fifo_empty && res_tready[owner];

  always_comb begin
    res_tvalid        = '0;
    res_tvalid[owner] = dot_res_tvalid && !fifo_empty;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                            err_orphan <= 1'b0;
    else if (dot_res_tvalid && fifo_empty) err_orphan <= 1'b1;
  end
endmodule

// File: tb/tb_vec_dot_arbiter.sv
// Directed bench: behavioural 30-cycle dot unit plus an owner-tagged scoreboard of expected results.
`timescale 1ns/1ps
module tb_vec_dot_arbiter;
  import vec_dot_arb_pkg::*;

  localparam int SIZE = 64;
  localparam int NR   = 4;
  localparam int MAXF = 32;
  localparam int LAT  = DOT_LATENCY;

  typedef struct { logic [SIZE-1:0] d; int due; } pipe_t;
  typedef struct { int owner; logic [SIZE-1:0] d; } exp_t;

  logic                         aclk = 1'b0;
  logic                         areset;
  logic [NR-1:0][2:0][SIZE-1:0] req_a_tdata;
  logic [NR-1:0][2:0][SIZE-1:0] req_b_tdata;
  logic [NR-1:0]                req_tvalid;
  logic [NR-1:0]                req_tready;
  logic [NR-1:0]                res_tvalid;
  logic [NR-1:0]                res_tready;
  logic [SIZE-1:0]              res_tdata;
  logic [SIZE-1:0]              dot_res_tdata;
  vec3_t                        dot_a_tdata;
  vec3_t                        dot_b_tdata;
  logic                         dot_tvalid;
  logic                         dot_a_tready;
  logic                         dot_b_tready;
  logic                         dot_res_tvalid;
  logic                         dot_res_tready;
  logic                         err_orphan;

  pipe_t pipe_q[$];
  exp_t  exp_q[$];
  int    fire_log[$];
  int    fire_cyc[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    ops_left[NR];
  int    seq[NR];
  int    res_cnt[NR];
  real   cur_a[NR][3];
  real   cur_b[NR][3];
  logic  inj;

  always #5 aclk = ~aclk;

  vec_dot_arbiter #(.SIZE(SIZE), .NUM_REQ(NR), .MAX_INFLIGHT(MAXF)) dut (
    .aclk           (aclk),
    .areset         (areset),
    .req_a_tdata    (req_a_tdata),
    .req_b_tdata    (req_b_tdata),
    .req_tvalid     (req_tvalid),
    .req_tready     (req_tready),
    .res_tdata      (res_tdata),
    .res_tvalid     (res_tvalid),
    .res_tready     (res_tready),
    .dot_a_tdata    (dot_a_tdata),
    .dot_b_tdata    (dot_b_tdata),
    .dot_tvalid     (dot_tvalid),
    .dot_a_tready   (dot_a_tready),
    .dot_b_tready   (dot_b_tready),
    .dot_res_tdata  (dot_res_tdata),
    .dot_res_tvalid (dot_res_tvalid),
    .dot_res_tready (dot_res_tready),
    .err_orphan     (err_orphan)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dot6(input real a0, input real a1, input real a2,
                                       input real b0, input real b1, input real b2);
    return $realtobits(a0 * b0 + a1 * b1 + a2 * b2);
  endfunction

  function automatic real gen(input int i, input int s, input int k, input bit is_b);
    if (is_b) return real'(k + 1) * 2.0 - real'(s) * 0.25;
    return real'(i + 1) + real'(s) * 0.5 + real'(k);
  endfunction

  task automatic load_gen(input int i);
    for (int k = 0; k < 3; k++) begin
      cur_a[i][k] = gen(i, seq[i], k, 1'b0);
      cur_b[i][k] = gen(i, seq[i], k, 1'b1);
    end
  endtask

  task automatic drive_req(input int i);
    req_tvalid[i] = (ops_left[i] > 0);
    for (int k = 0; k < 3; k++) begin
      req_a_tdata[i][k] = $realtobits(cur_a[i][k]);
      req_b_tdata[i][k] = $realtobits(cur_b[i][k]);
    end
  endtask

  task automatic update_model_out();
    if (inj) begin
      dot_res_tvalid = 1'b1;
      dot_res_tdata  = 64'h0bad_0bad_0bad_0bad;
    end else if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
      dot_res_tvalid = 1'b1;
      dot_res_tdata  = pipe_q[0].d;
    end else begin
      dot_res_tvalid = 1'b0;
      dot_res_tdata  = '0;
    end
  endtask

  // One clock: settle, record handshakes, advance, then refresh stimulus and dot-unit outputs.
  task automatic tick();
    logic [NR-1:0] hs;
    int            idx;
    #1;
    hs = req_tvalid & req_tready;
    check("res_onehot", 64'($onehot0(res_tvalid)), 64'(1));
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        fire_log.push_back(i);
        fire_cyc.push_back(cyc);
        exp_q.push_back('{i, dot6(cur_a[i][0], cur_a[i][1], cur_a[i][2],
                                  cur_b[i][0], cur_b[i][1], cur_b[i][2])});
      end
    end
    if (dot_tvalid && dot_a_tready && dot_b_tready)
      pipe_q.push_back('{dot6($bitstoreal(dot_a_tdata[0]), $bitstoreal(dot_a_tdata[1]),
                              $bitstoreal(dot_a_tdata[2]), $bitstoreal(dot_b_tdata[0]),
                              $bitstoreal(dot_b_tdata[1]), $bitstoreal(dot_b_tdata[2])),
                         cyc + LAT});
    for (int i = 0; i < NR; i++) begin
      if (res_tvalid[i] && res_tready[i]) begin
        idx = -1;
        foreach (exp_q[j]) if (idx < 0 && exp_q[j].owner == i) idx = j;
        check("res_owner_expected", 64'(idx >= 0), 64'(1));
        if (idx >= 0) begin
          check("res_data", res_tdata, exp_q[idx].d);
          exp_q.delete(idx);
        end
        res_cnt[i]++;
      end
    end
    if (dot_res_tvalid && dot_res_tready && !inj && pipe_q.size() > 0) void'(pipe_q.pop_front());
    @(posedge aclk);
    cyc++;
    @(negedge aclk);
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        seq[i]++;
        ops_left[i]--;
        load_gen(i);
        drive_req(i);
      end
    end
    update_model_out();
  endtask

  task automatic drain(input int budget, input string tag);
    for (int n = 0; n < budget && exp_q.size() > 0; n++) tick();
    check(tag, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    bit            found;
    logic [63:0]   held [3];

    areset       = 1'b1;
    inj          = 1'b0;
    dot_a_tready = 1'b1;
    dot_b_tready = 1'b1;
    res_tready   = '1;
    req_tvalid   = '0;
    req_a_tdata  = '0;
    req_b_tdata  = '0;
    for (int i = 0; i < NR; i++) begin
      ops_left[i] = 0;
      seq[i]      = 0;
      res_cnt[i]  = 0;
      load_gen(i);
    end
    update_model_out();
    #1;
    check("rst_res_tvalid", 64'(res_tvalid), 64'(0));
    check("rst_req_tready", 64'(req_tready), 64'(0));
    check("rst_dot_tvalid", 64'(dot_tvalid), 64'(0));
    check("rst_dot_res_tready", 64'(dot_res_tready), 64'(1));
    check("rst_err_orphan", 64'(err_orphan), 64'(0));
    repeat (2) @(negedge aclk);
    areset = 1'b0;

    // All four requesters streaming: strict round-robin, one issue per cycle.
    fire_log.delete(); fire_cyc.delete();
    for (int i = 0; i < NR; i++) begin ops_left[i] = 2; drive_req(i); end
    repeat (8) tick();
    check("rr_fire_count", 64'(fire_log.size()), 64'(8));
    for (int n = 0; n < 8 && n < fire_log.size(); n++) check("rr_order", 64'(fire_log[n]), 64'(n % NR));
    if (fire_cyc.size() == 8) check("rr_back_to_back", 64'(fire_cyc[7] - fire_cyc[0]), 64'(7));
    drain(60, "rr_drain");
    for (int i = 0; i < NR; i++) check("rr_results_per_req", 64'(res_cnt[i]), 64'(2));

    // Single op (1,2,3).(4,5,6) = 32.0 from requester 0, exactly LAT cycles later.
    fire_log.delete(); fire_cyc.delete();
    cur_a[0][0] = 1.0; cur_a[0][1] = 2.0; cur_a[0][2] = 3.0;
    cur_b[0][0] = 4.0; cur_b[0][1] = 5.0; cur_b[0][2] = 6.0;
    ops_left[0] = 1; drive_req(0);
    #1;
    check("single_req_tready", 64'(req_tready), 64'(4'b0001));
    tick();
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      #1;
      if (res_tvalid != '0) found = 1'b1;
      else tick();
    end
    check("single_found", 64'(found), 64'(1));
    check("single_res_tvalid", 64'(res_tvalid), 64'(4'b0001));
    check("single_res_tdata", res_tdata, 64'h4040_0000_0000_0000);
    if (fire_cyc.size() > 0) check("single_latency", 64'(cyc - fire_cyc[0]), 64'(LAT));
    tick();
    drain(5, "single_drain");

    // Stalled offer from requester 2 must stay granted while requester 1 joins.
    dot_a_tready = 1'b0;
    ops_left[2] = 1; drive_req(2);
    #1;
    check("hold_first_tvalid", 64'(dot_tvalid), 64'(1));
    for (int k = 0; k < 3; k++) held[k] = $realtobits(cur_a[2][k]);
    tick();
    ops_left[1] = 1; drive_req(1);
    for (int n = 0; n < 4; n++) begin
      #1;
      check("hold_tvalid", 64'(dot_tvalid), 64'(1));
      check("hold_req_tready", 64'(req_tready), 64'(0));
      for (int k = 0; k < 3; k++) check("hold_a_data", dot_a_tdata[k], held[k]);
      tick();
    end
    dot_a_tready = 1'b1;
    fire_log.delete();
    tick(); tick();
    check("hold_fire_count", 64'(fire_log.size()), 64'(2));
    if (fire_log.size() == 2) begin
      check("hold_first_fire", 64'(fire_log[0]), 64'(2));
      check("hold_second_fire", 64'(fire_log[1]), 64'(1));
    end
    drain(60, "hold_drain");

    // Result back-pressure fills the in-flight window; issue resumes one cycle after the first pop.
    res_tready[0] = 1'b0;
    fire_log.delete();
    ops_left[0] = 34; load_gen(0); drive_req(0);
    repeat (45) tick();
    check("full_fire_count", 64'(fire_log.size()), 64'(MAXF));
    #1;
    check("full_no_issue", 64'(dot_tvalid), 64'(0));
    res_tready[0] = 1'b1;
    #1;
    check("full_pop_res_tvalid", 64'(res_tvalid), 64'(4'b0001));
    check("full_no_issue_on_pop", 64'(dot_tvalid), 64'(0));
    tick();
    #1;
    check("full_resume", 64'(dot_tvalid), 64'(1));
    drain(150, "full_drain");
    check("full_total_fires", 64'(fire_log.size()), 64'(34));

    // Result with nothing outstanding is consumed, dropped and flagged.
    inj = 1'b1; update_model_out();
    #1;
    check("orphan_tready", 64'(dot_res_tready), 64'(1));
    check("orphan_no_res", 64'(res_tvalid), 64'(0));
    check("orphan_not_yet", 64'(err_orphan), 64'(0));
    tick();
    inj = 1'b0; update_model_out();
    repeat (3) tick();
    #1;
    check("orphan_sticky", 64'(err_orphan), 64'(1));

    // Reset with ten ops outstanding, then one fresh op must come back only to requester 3.
    fire_log.delete();
    ops_left[0] = 3; ops_left[1] = 3; ops_left[2] = 2; ops_left[3] = 2;
    for (int i = 0; i < NR; i++) begin load_gen(i); drive_req(i); end
    repeat (12) tick();
    check("rst_inflight_fires", 64'(fire_log.size()), 64'(10));
    areset = 1'b1;
    pipe_q.delete(); exp_q.delete();
    ops_left[1] = 1; drive_req(1);
    update_model_out();
    #1;
    check("midrst_dot_tvalid", 64'(dot_tvalid), 64'(0));
    check("midrst_req_tready", 64'(req_tready), 64'(0));
    check("midrst_res_tvalid", 64'(res_tvalid), 64'(0));
    check("midrst_dot_res_tready", 64'(dot_res_tready), 64'(1));
    check("midrst_err_orphan", 64'(err_orphan), 64'(0));
    repeat (2) tick();
    for (int i = 0; i < NR; i++) begin
      ops_left[i] = (i == 3) ? 1 : 0;
      res_cnt[i]  = 0;
      load_gen(i);
      drive_req(i);
    end
    areset = 1'b0;
    repeat (45) tick();
    for (int i = 0; i < NR; i++) check("post_rst_routing", 64'(res_cnt[i]), 64'((i == 3) ? 1 : 0));
    check("post_rst_pending", 64'(exp_q.size()), 64'(0));
    check("post_rst_err_orphan", 64'(err_orphan), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/vec_dot_arbiter.md
# vec_dot_arbiter

Shares one 3-element floating-point dot-product unit (30-cycle pipelined, AXI-stream in/out) among NUM_REQ requesters. Round-robin arbitration picks one requester's operand pair per cycle, an in-order owner-tag FIFO records who issued each operation, and each result returns to its owner's result port. Sits between the ray/shading clients and the single `vec_dot` instance.

## Interface
- SIZE, 64: float width in bits
- NUM_REQ, 4: number of requesters (2..8)
- MAX_INFLIGHT, 32: tag FIFO depth; a power of two ≥ dot latency (30) + 2
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset; drives the dot unit's aresetn as ~areset
- req_a_tdata / req_b_tdata  in  [NUM_REQ-1:0][2:0][SIZE-1:0]  operand vectors
- req_tvalid  in  NUM_REQ  per-requester operand valid (a and b travel together)
- req_tready  out  NUM_REQ  per-requester operand accept
- res_tdata  out  SIZE  result data, broadcast to all requesters
- res_tvalid  out  NUM_REQ  one-hot result valid
- res_tready  in  NUM_REQ  per-requester result ready
- dot_a_tdata / dot_b_tdata  out  [2:0][SIZE-1:0]  to dot unit
- dot_tvalid  out  1  drives both s_axis_a_tvalid and s_axis_b_tvalid
- dot_a_tready / dot_b_tready  in  1  from dot unit
- dot_res_tdata  in  SIZE; dot_res_tvalid  in  1; dot_res_tready  out  1
- err_orphan  out  1  sticky: result arrived with tag FIFO empty

## Operation
- Issue FSM, two states:
  - ARB: grant = first valid requester at or after rr_ptr (wrapping modulo NUM_REQ), chosen combinationally.
  - HOLD: grant is locked and not re-evaluated.
- Issue gating: issue_ok = (inflight_cnt < MAX_INFLIGHT). dot_tvalid = issue_ok && req_tvalid[grant] && (some requester valid).
- Fire = dot_tvalid && dot_a_tready && dot_b_tready.
- On fire:
  - push grant into tag FIFO
  - rr_ptr ← (grant+1) mod NUM_REQ
  - state ← ARB
- If dot_tvalid && !fire: state ← HOLD. Grant and data stay stable until fire (AXI no-retract). Requesters must not drop tvalid once asserted.
- req_tready[i] = (grant==i) && issue_ok && dot_a_tready && dot_b_tready.
- Return path:
  - owner = FIFO head
  - res_tvalid[owner] = dot_res_tvalid && !fifo_empty
  - dot_res_tready = res_tready[owner] || fifo_empty
  - On result handshake, pop the FIFO.
- Orphan result (dot_res_tvalid while FIFO empty): consume and drop it; set err_orphan until reset.
- inflight_cnt: +1 on fire, −1 on pop, unchanged when both occur in the same cycle. Width is clog2(MAX_INFLIGHT)+1.
- Back-pressure on the result path propagates into the dot pipeline. Issue stalls only through dot tready or a full count.

## Timing
- Reset values:
  - all *_tvalid = 0, req_tready = 0, dot_res_tready = 1 (FIFO empty)
  - err_orphan = 0, rr_ptr = 0, state = ARB, FIFO empty, inflight_cnt = 0
- Reset mid-operation clears all tags and the count at once. The dot unit is reset by the same signal, so no stale result returns.
- Arbitration adds 0 cycles: a requester valid in cycle t can fire in cycle t.
- Return routing is combinational from the FIFO head: 0 added cycles. End-to-end latency equals the dot unit latency (30).
- Full boundary: at inflight_cnt = MAX_INFLIGHT, no issue even if a pop occurs that cycle. Issue resumes the next cycle.
- Throughput: one issue per cycle. With all requesters valid, the grant order is 0,1,2,3,0,…

## Structure
- Package `vec_dot_arb_pkg`:
  - localparam TAG_W = $clog2(NUM_REQ)
  - typedef enum {ARB, HOLD} arb_state_t
  - typedef logic [2:0][SIZE-1:0] vec3_t
- Sub-module `tag_fifo`:
  - synchronous, WIDTH × DEPTH
  - push/pop/full/empty/count
  - simultaneous push and pop allowed when not full
  - asynchronous active-high reset

## Test plan
- Single requester 0 sends a=(1,2,3), b=(4,5,6) → res_tvalid=0001 exactly 30 cycles after fire, res_tdata=32.0.
- All 4 requesters valid continuously for 8 ops → grant sequence 0,1,2,3,0,1,2,3; each requester receives its own 2 results in order.
- dot_a_tready low for 5 cycles while requester 2 waits and requester 1 raises valid → grant stays 2, dot_a_tdata stable; requester 2 fires first once ready returns.
- res_tready[owner]=0 for 40 cycles under continuous issue → issue stops once inflight_cnt=32; no result lost or misrouted; issue resumes the cycle after the count drops below 32.
- Inject dot_res_tvalid with FIFO empty → dot_res_tready=1, no res_tvalid, err_orphan=1 until areset.
- Assert areset with 10 ops in flight → all outputs reach their reset values immediately; the next op issued after release returns only to its own requester.
